pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage OTTER pipeline, which has no forwarding.
- Inspects the decode-stage instruction against the rd of older instructions in execute and memory.
- Inserts the required number of bubbles using a counted stall.
- Flushes on taken branches/jumps and freezes the whole pipeline while data memory is busy.
- Drives every pipeline-register enable/clear and the PC write; keeps hazard performance counters.

---
 rtl/pipe_hazard_ctrl_if.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 85 ++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decode/hazard inputs and pipeline-control outputs of the hazard sequencer
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
    logic [31:0]      dec_ir;
    logic [4:0]       ex_rd;
    logic             ex_reg_wr;
    logic [4:0]       mem_rd;
    logic             mem_reg_wr;
    logic             br_taken;
    logic             mem_busy;
    logic             pc_write;
    logic             if_id_en;
    logic             if_id_clear;
    logic             id_ex_en;
    logic             id_ex_clear;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output dec_ir, ex_rd, ex_reg_wr, mem_rd, mem_reg_wr, br_taken, mem_busy,
        input  pc_write, if_id_en, if_id_clear, id_ex_en, id_ex_clear, ex_mem_en, mem_wb_en,
               stall_cycles, flush_count
    );
    modport slave (
        input  dec_ir, ex_rd, ex_reg_wr, mem_rd, mem_reg_wr, br_taken, mem_busy,
        output pc_write, if_id_en, if_id_clear, id_ex_en, id_ex_clear, ex_mem_en, mem_wb_en,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/freeze sequencer for a 5-stage pipeline without forwarding
module pipe_hazard_ctrl #(
    parameter int EX_BUBBLES  = 2,
    parameter int MEM_BUBBLES = 1,
    parameter int CNT_W       = 32
) (
    input logic clk,
    input logic rst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, STALL, FREEZE} state_t;
    localparam logic [1:0] EXB = 2'(EX_BUBBLES);
    localparam logic [1:0] MEMB = 2'(MEM_BUBBLES);

    state_t           state, ret_state;
    logic [1:0]       cnt, need;
    logic [6:0]       op;
    logic [4:0]       rs1, rs2;
    logic             use1, use2, need_ex, need_mem, frz, flush, stall;
    logic [CNT_W-1:0] stall_q, flush_q;

    assign op   = bus.dec_ir[6:0];
    assign rs1  = bus.dec_ir[19:15];
    assign rs2  = bus.dec_ir[24:20];
    assign use1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    assign use2 = op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;

    assign need_ex  = bus.ex_reg_wr && ((use1 && rs1 != 5'd0 && rs1 == bus.ex_rd) ||
                                        (use2 && rs2 != 5'd0 && rs2 == bus.ex_rd));
    assign need_mem = bus.mem_reg_wr && ((use1 && rs1 != 5'd0 && rs1 == bus.mem_rd) ||
                                         (use2 && rs2 != 5'd0 && rs2 == bus.mem_rd));
    assign need     = need_ex ? EXB : need_mem ? MEMB : 2'd0;

    // Reset forces pass values; freeze beats flush, flush beats stall
    assign frz   = !rst && (state == FREEZE || bus.mem_busy);
    assign flush = !rst && !frz && bus.br_taken;
    assign stall = !rst && !frz && !flush && (state == STALL || need != 2'd0);

    assign bus.pc_write     = !frz && !stall;
    assign bus.if_id_en     = !frz && !stall;
    assign bus.if_id_clear  = flush;
    assign bus.id_ex_en     = !frz;
    assign bus.id_ex_clear  = flush || stall;
    assign bus.ex_mem_en    = !frz;
    assign bus.mem_wb_en    = !frz;
    assign bus.stall_cycles = stall_q;
    assign bus.flush_count  = flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            ret_state <= RUN;
            cnt       <= 2'd0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            if (stall && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (flush && flush_q != '1) flush_q <= flush_q + 1'b1;
            case (state)
                RUN: begin
                    if (bus.mem_busy) begin
                        ret_state <= RUN;
                        state     <= FREEZE;
                    end else if (!bus.br_taken && need != 2'd0) begin
                        cnt   <= need - 2'd1;
                        state <= (need == 2'd1) ? RUN : STALL;
                    end
                end
                STALL: begin
                    if (bus.mem_busy) begin
                        ret_state <= STALL;
                        state     <= FREEZE;
                    end else if (bus.br_taken) begin
                        cnt   <= 2'd0;
                        state <= RUN;
                    end else begin
                        cnt   <= cnt - 2'd1;
                        state <= (cnt <= 2'd1) ? RUN : STALL;
                    end
                end
                default: if (!bus.mem_busy) state <= ret_state;
            endcase
        end
    end
endmodule
